cpu_gpr_dbg: RTL and testbench
==============================

CPU_GPR_DBG -- requirements
Module: cpu_gpr_dbg

Interface
Constants (name, default, meaning):
REQ-001 The block SHALL use REG_ADDR_WIDTH, default 5, as the GPR address width (32 registers, index 0..31).
REQ-002 The block SHALL use WORD_DATA_WIDTH, default 32, as the GPR data width.

Ports (name, direction, width, meaning):
REQ-003 The block SHALL have port clk, input, 1: the single clock; all state updates occur on the rising edge.
REQ-004 The block SHALL have port reset, input, 1: asynchronous, active-low reset.
REQ-005 The block SHALL have port dbg_req, input, 1: host request, level-sensitive.
REQ-006 The block SHALL have port dbg_cmd, input, 2: 00 read, 01 write, 10 dump, 11 clear.
REQ-007 The block SHALL have port dbg_addr, input, 5: target register for read and write.
REQ-008 The block SHALL have port dbg_wdata, input, 32: write data.
REQ-009 The block SHALL have port dbg_busy, output, 1: a command is in progress.
REQ-010 The block SHALL have port dbg_ack, output, 1: one-cycle command-complete pulse.
REQ-011 The block SHALL have port dbg_rvalid, output, 1: one-cycle pulse marking dbg_rdata and dbg_rindex as valid.
REQ-012 The block SHALL have port dbg_rdata, output, 32: captured register value.
REQ-013 The block SHALL have port dbg_rindex, output, 5: index of the register in dbg_rdata.
REQ-014 The block SHALL have port gpr_rd_addr, output, 5: drives the GPR read port (rd_addr) address.
REQ-015 The block SHALL have port gpr_rd_data, input, 32: combinational GPR read data for gpr_rd_addr.
REQ-016 The block SHALL have port gpr_we_n, output, 1: active-low GPR write enable.
REQ-017 The block SHALL have port gpr_wr_addr, output, 5: GPR write address.
REQ-018 The block SHALL have port gpr_wr_data, output, 32: GPR write data.

Function
REQ-019 The FSM SHALL have states IDLE, READ, WRITE, DUMP and CLEAR; all outputs SHALL be registered.
REQ-020 In IDLE with dbg_req=1 at edge E0, the block SHALL latch dbg_cmd, dbg_addr and dbg_wdata, set dbg_busy=1, and enter the state selected by dbg_cmd.
REQ-021 A request SHALL be accepted only in IDLE; dbg_req and all command inputs SHALL be ignored while dbg_busy=1.
REQ-022 For READ, E0 SHALL set gpr_rd_addr=dbg_addr; at E1 the block SHALL capture gpr_rd_data into dbg_rdata, set dbg_rindex=addr, pulse dbg_rvalid and dbg_ack, clear dbg_busy, and return to IDLE.
REQ-023 For WRITE, E0 SHALL set gpr_we_n=0, gpr_wr_addr=addr and gpr_wr_data=wdata; at E1 the block SHALL set gpr_we_n=1, pulse dbg_ack, clear dbg_busy, and return to IDLE, giving exactly one write cycle.
REQ-024 For DUMP, E0 SHALL set gpr_rd_addr=0 and an index counter to 0.
REQ-025 For DUMP, at each edge Ek (k=1..32) the block SHALL set dbg_rdata=gpr_rd_data, set dbg_rindex=k-1, pulse dbg_rvalid, and advance gpr_rd_addr to k.
REQ-026 DUMP SHALL emit 32 consecutive dbg_rvalid cycles; dbg_ack SHALL coincide with the rvalid for index 31, and the state SHALL then return to IDLE.
REQ-027 For CLEAR, E0 SHALL set gpr_we_n=0, gpr_wr_addr=0 and gpr_wr_data=0; at Ek (k=1..31) it SHALL set gpr_wr_addr=k.
REQ-028 At E32, CLEAR SHALL set gpr_we_n=1, pulse dbg_ack and return to IDLE, giving 32 consecutive write cycles.
REQ-029 The 5-bit index counter SHALL stop at 31 and SHALL NOT wrap; gpr_rd_addr SHALL hold at 0 (5-bit wrap) after a DUMP completes.
REQ-030 dbg_busy SHALL deassert in the same cycle that dbg_ack is high; if dbg_req is still high, the next command SHALL be accepted at the following edge (E_last+1).
REQ-031 dbg_rvalid and dbg_ack SHALL each be high for exactly one cycle per event; dbg_rdata and dbg_rindex SHALL hold until the next capture.
REQ-032 Register 0 SHALL be treated as an ordinary register and SHALL be both writable and readable.

Reset
REQ-033 While reset=0, the block SHALL immediately (asynchronously) set state=IDLE, gpr_we_n=1, dbg_busy=0, dbg_ack=0 and dbg_rvalid=0, and all address, data, index and counter registers to 0.
REQ-034 A reset asserted mid-command SHALL abort the command with no dbg_ack, and gpr_we_n SHALL go to 1 without waiting for a clock edge.
REQ-035 The first request after release SHALL be accepted at the first rising edge that samples reset=1 and dbg_req=1.

Verification
REQ-036 WRITE addr 1, data 0x00001234, then READ addr 1 -> exactly one gpr_we_n=0 cycle; then dbg_rdata=0x00001234, dbg_rindex=1, rvalid and ack together one edge after accept.
REQ-037 WRITE r0=0x0000AAAA, r2=0x00005678, then DUMP -> 32 consecutive rvalid pulses with rindex 0..31; index 0 = 0x0000AAAA, index 2 = 0x00005678; ack on index 31.
REQ-038 CLEAR then DUMP -> 32 write cycles with wr_addr 0..31 and wr_data 0, then all 32 dumped values = 0x00000000.
REQ-039 During DUMP, pulse dbg_req with cmd=01 -> ignored: no gpr_we_n=0 and still exactly 32 rvalid pulses.
REQ-040 dbg_req held high with cmd=01 -> write at E0, ack at E1, re-accept at E2, with busy low only in the ack cycle.
REQ-041 reset driven low 10 cycles into CLEAR -> gpr_we_n=1 and dbg_busy=0 before the next edge, no ack, and outputs at reset values.

Source files
------------

// File: rtl/cpu_gpr_dbg.sv
// Debug host port onto a CPU general-purpose register file: single read/write,
// full-file dump streamed out on dbg_rvalid, and a clear of every register to zero.
module cpu_gpr_dbg #(
   parameter int REG_ADDR_WIDTH  = 5,
   parameter int WORD_DATA_WIDTH = 32
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       dbg_req,
   input  logic [1:0]                 dbg_cmd,
   input  logic [REG_ADDR_WIDTH-1:0]  dbg_addr,
   input  logic [WORD_DATA_WIDTH-1:0] dbg_wdata,
   output logic                       dbg_busy,
   output logic                       dbg_ack,
   output logic                       dbg_rvalid,
   output logic [WORD_DATA_WIDTH-1:0] dbg_rdata,
   output logic [REG_ADDR_WIDTH-1:0]  dbg_rindex,
   output logic [REG_ADDR_WIDTH-1:0]  gpr_rd_addr,
   input  logic [WORD_DATA_WIDTH-1:0] gpr_rd_data,
   output logic                       gpr_we_n,
   output logic [REG_ADDR_WIDTH-1:0]  gpr_wr_addr,
   output logic [WORD_DATA_WIDTH-1:0] gpr_wr_data
);

   typedef enum logic [2:0] {IDLE, READ, WRITE, DUMP, CLEAR} state_e;

   localparam logic [REG_ADDR_WIDTH-1:0] LastIdx = '1;

   state_e                       state_q, state_d;
   logic                         busy_q, busy_d;
   logic                         ack_q, ack_d;
   logic                         rvalid_q, rvalid_d;
   logic [WORD_DATA_WIDTH-1:0]   rdata_q, rdata_d;
   logic [REG_ADDR_WIDTH-1:0]    rindex_q, rindex_d;
   logic [REG_ADDR_WIDTH-1:0]    rdAddr_q, rdAddr_d;
   logic                         weN_q, weN_d;
   logic [REG_ADDR_WIDTH-1:0]    wrAddr_q, wrAddr_d;
   logic [WORD_DATA_WIDTH-1:0]   wrData_q, wrData_d;
   logic [REG_ADDR_WIDTH-1:0]    addr_q, addr_d;
   logic [REG_ADDR_WIDTH-1:0]    cnt_q, cnt_d;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q  <= IDLE;
         busy_q   <= 1'b0;
         ack_q    <= 1'b0;
         rvalid_q <= 1'b0;
         rdata_q  <= '0;
         rindex_q <= '0;
         rdAddr_q <= '0;
         weN_q    <= 1'b1;
         wrAddr_q <= '0;
         wrData_q <= '0;
         addr_q   <= '0;
         cnt_q    <= '0;
      end else begin
         state_q  <= state_d;
         busy_q   <= busy_d;
         ack_q    <= ack_d;
         rvalid_q <= rvalid_d;
         rdata_q  <= rdata_d;
         rindex_q <= rindex_d;
         rdAddr_q <= rdAddr_d;
         weN_q    <= weN_d;
         wrAddr_q <= wrAddr_d;
         wrData_q <= wrData_d;
         addr_q   <= addr_d;
         cnt_q    <= cnt_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      busy_d   = busy_q;
      ack_d    = 1'b0;
      rvalid_d = 1'b0;
      rdata_d  = rdata_q;
      rindex_d = rindex_q;
      rdAddr_d = rdAddr_q;
      weN_d    = weN_q;
      wrAddr_d = wrAddr_q;
      wrData_d = wrData_q;
      addr_d   = addr_q;
      cnt_d    = cnt_q;

      unique case (state_q)
         IDLE: begin
            if (dbg_req) begin
               busy_d = 1'b1;
               addr_d = dbg_addr;
               unique case (dbg_cmd)
                  2'b00: begin
                     rdAddr_d = dbg_addr;
                     state_d  = READ;
                  end
                  2'b01: begin
                     weN_d    = 1'b0;
                     wrAddr_d = dbg_addr;
                     wrData_d = dbg_wdata;
                     state_d  = WRITE;
                  end
                  2'b10: begin
                     rdAddr_d = '0;
                     cnt_d    = '0;
                     state_d  = DUMP;
                  end
                  default: begin
                     weN_d    = 1'b0;
                     wrAddr_d = '0;
                     wrData_d = '0;
                     cnt_d    = '0;
                     state_d  = CLEAR;
                  end
               endcase
            end
         end
         READ: begin
            rdata_d  = gpr_rd_data;
            rindex_d = addr_q;
            rvalid_d = 1'b1;
            ack_d    = 1'b1;
            busy_d   = 1'b0;
            state_d  = IDLE;
         end
         WRITE: begin
            weN_d   = 1'b1;
            ack_d   = 1'b1;
            busy_d  = 1'b0;
            state_d = IDLE;
         end
         DUMP: begin
            // Read address runs one ahead of the index; it wraps back to 0 on the final step.
            rdata_d  = gpr_rd_data;
            rindex_d = cnt_q;
            rvalid_d = 1'b1;
            rdAddr_d = rdAddr_q + 1'b1;
            if (cnt_q == LastIdx) begin
               ack_d   = 1'b1;
               busy_d  = 1'b0;
               state_d = IDLE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         CLEAR: begin
            if (cnt_q == LastIdx) begin
               weN_d   = 1'b1;
               ack_d   = 1'b1;
               busy_d  = 1'b0;
               state_d = IDLE;
            end else begin
               cnt_d    = cnt_q + 1'b1;
               wrAddr_d = cnt_q + 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign dbg_busy    = busy_q;
   assign dbg_ack     = ack_q;
   assign dbg_rvalid  = rvalid_q;
   assign dbg_rdata   = rdata_q;
   assign dbg_rindex  = rindex_q;
   assign gpr_rd_addr = rdAddr_q;
   assign gpr_we_n    = weN_q;
   assign gpr_wr_addr = wrAddr_q;
   assign gpr_wr_data = wrData_q;

endmodule

// File: tb/tb_cpu_gpr_dbg.sv
// Directed bench for cpu_gpr_dbg with a behavioural register file and
// scoreboard queues for expected reads (rvalid) and expected writes (we_n low).
module tb_cpu_gpr_dbg;

   typedef struct packed {
      logic [4:0]  idx;
      logic [31:0] data;
   } entry_t;

   logic        clk = 1'b0;
   logic        reset;
   logic        dbg_req;
   logic [1:0]  dbg_cmd;
   logic [4:0]  dbg_addr;
   logic [31:0] dbg_wdata;
   logic        dbg_busy, dbg_ack, dbg_rvalid;
   logic [31:0] dbg_rdata;
   logic [4:0]  dbg_rindex, gpr_rd_addr, gpr_wr_addr;
   logic [31:0] gpr_rd_data, gpr_wr_data;
   logic        gpr_we_n;

   logic [31:0] mem [32];
   logic [31:0] model [32];
   logic        memLoad;

   int checks = 0;
   int errors = 0;
   int rvalidCount = 0;
   int weCount = 0;
   int ackCount = 0;

   entry_t rdQ[$];
   entry_t wrQ[$];

   cpu_gpr_dbg #(.REG_ADDR_WIDTH(5), .WORD_DATA_WIDTH(32)) dut (
      .clk(clk), .reset(reset),
      .dbg_req(dbg_req), .dbg_cmd(dbg_cmd), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
      .dbg_busy(dbg_busy), .dbg_ack(dbg_ack), .dbg_rvalid(dbg_rvalid),
      .dbg_rdata(dbg_rdata), .dbg_rindex(dbg_rindex),
      .gpr_rd_addr(gpr_rd_addr), .gpr_rd_data(gpr_rd_data),
      .gpr_we_n(gpr_we_n), .gpr_wr_addr(gpr_wr_addr), .gpr_wr_data(gpr_wr_data)
   );

   always #5 clk = ~clk;

   // Register file seen by the DUT: combinational read, write on the rising edge.
   always @(posedge clk) begin
      if (memLoad) begin
         for (int i = 0; i < 32; i++) mem[i] <= 32'hA500_0000 | i;
      end else if (gpr_we_n === 1'b0) begin
         mem[gpr_wr_addr] <= gpr_wr_data;
      end
   end

   assign gpr_rd_data = mem[gpr_rd_addr];

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   always @(negedge clk) begin
      if (reset === 1'b1) begin
         if (dbg_rvalid === 1'b1) begin
            rvalidCount++;
            if (rdQ.size() == 0) begin
               checkOutput("unexpected_rvalid", dbg_rvalid, 1'b0);
            end else begin
               entry_t e;
               e = rdQ.pop_front();
               checkOutput("rindex", dbg_rindex, e.idx);
               checkOutput("rdata", dbg_rdata, e.data);
            end
         end
         if (gpr_we_n === 1'b0) begin
            weCount++;
            if (wrQ.size() == 0) begin
               checkOutput("unexpected_write", gpr_we_n, 1'b1);
            end else begin
               entry_t w;
               w = wrQ.pop_front();
               checkOutput("wr_addr", gpr_wr_addr, w.idx);
               checkOutput("wr_data", gpr_wr_data, w.data);
            end
         end
         if (dbg_ack === 1'b1) ackCount++;
      end
   end

   // Called #1 after a rising edge; returns #1 after the accepting edge E0.
   task automatic applyStimulus(input logic [1:0] cmd, input logic [4:0] addr, input logic [31:0] wdata);
      dbg_req   = 1'b1;
      dbg_cmd   = cmd;
      dbg_addr  = addr;
      dbg_wdata = wdata;
      @(posedge clk);
      #1 dbg_req = 1'b0;
   endtask

   // Counts edges after E0 until ack; optionally injects a one-cycle write request mid-command.
   task automatic waitAck(input int glitchAt, output int n);
      n = 0;
      do begin
         @(posedge clk);
         #1;
         n++;
         if (glitchAt != 0 && n == glitchAt) begin
            dbg_req   = 1'b1;
            dbg_cmd   = 2'b01;
            dbg_addr  = 5'd7;
            dbg_wdata = 32'hDEAD_0007;
         end else if (glitchAt != 0 && n == glitchAt + 1) begin
            dbg_req = 1'b0;
         end
      end while (dbg_ack !== 1'b1 && n < 40);
      dbg_req = 1'b0;
   endtask

   task automatic pushWrite(input int idx, input logic [31:0] data);
      entry_t e;
      e.idx  = 5'(idx);
      e.data = data;
      wrQ.push_back(e);
      model[idx] = data;
   endtask

   task automatic pushRead(input int idx);
      entry_t e;
      e.idx  = 5'(idx);
      e.data = model[idx];
      rdQ.push_back(e);
   endtask

   initial begin
      int n;
      int rvBefore;
      int ackBefore;

      reset     = 1'b0;
      memLoad   = 1'b1;
      dbg_req   = 1'b0;
      dbg_cmd   = 2'b00;
      dbg_addr  = 5'd0;
      dbg_wdata = 32'h0;
      for (int i = 0; i < 32; i++) model[i] = 32'hA500_0000 | i;

      @(posedge clk);
      #1 memLoad = 1'b0;
      @(posedge clk);
      #1;
      checkOutput("reset_busy", dbg_busy, 1'b0);
      checkOutput("reset_ack", dbg_ack, 1'b0);
      checkOutput("reset_rvalid", dbg_rvalid, 1'b0);
      checkOutput("reset_we_n", gpr_we_n, 1'b1);
      checkOutput("reset_rdata", dbg_rdata, 32'h0);
      checkOutput("reset_rd_addr", gpr_rd_addr, 5'd0);
      checkOutput("reset_wr_data", gpr_wr_data, 32'h0);
      reset = 1'b1;
      @(posedge clk);
      #1;

      // Single write followed by a read of the same register.
      pushWrite(1, 32'h0000_1234);
      applyStimulus(2'b01, 5'd1, 32'h0000_1234);
      checkOutput("wr_busy_e0", dbg_busy, 1'b1);
      checkOutput("wr_we_n_e0", gpr_we_n, 1'b0);
      waitAck(0, n);
      checkOutput("wr_ack_latency", n, 1);
      checkOutput("wr_we_n_e1", gpr_we_n, 1'b1);
      checkOutput("wr_busy_e1", dbg_busy, 1'b0);
      checkOutput("wr_count", weCount, 1);

      pushRead(1);
      applyStimulus(2'b00, 5'd1, 32'h0);
      checkOutput("rd_addr_e0", gpr_rd_addr, 5'd1);
      waitAck(0, n);
      checkOutput("rd_ack_latency", n, 1);
      checkOutput("rd_rvalid_with_ack", dbg_rvalid, 1'b1);
      checkOutput("rd_busy_e1", dbg_busy, 1'b0);
      @(posedge clk);
      #1;
      checkOutput("rd_ack_one_cycle", dbg_ack, 1'b0);
      checkOutput("rd_rdata_hold", dbg_rdata, 32'h0000_1234);

      // Write r0 and r2, then dump with an ignored write request in the middle.
      pushWrite(0, 32'h0000_AAAA);
      applyStimulus(2'b01, 5'd0, 32'h0000_AAAA);
      waitAck(0, n);
      pushWrite(2, 32'h0000_5678);
      applyStimulus(2'b01, 5'd2, 32'h0000_5678);
      waitAck(0, n);
      for (int i = 0; i < 32; i++) pushRead(i);
      rvBefore = rvalidCount;
      applyStimulus(2'b10, 5'd0, 32'h0);
      waitAck(5, n);
      checkOutput("dump_ack_latency", n, 32);
      checkOutput("dump_ack_index", dbg_rindex, 5'd31);
      checkOutput("dump_rd_addr_wrap", gpr_rd_addr, 5'd0);
      @(posedge clk);
      #1;
      checkOutput("dump_rvalid_count", rvalidCount - rvBefore, 32);
      checkOutput("dump_no_write", weCount, 3);

      // Clear every register, then dump to confirm all zero.
      for (int i = 0; i < 32; i++) pushWrite(i, 32'h0);
      applyStimulus(2'b11, 5'd9, 32'hFFFF_FFFF);
      waitAck(0, n);
      checkOutput("clear_ack_latency", n, 32);
      checkOutput("clear_we_n_done", gpr_we_n, 1'b1);
      checkOutput("clear_write_count", weCount, 35);
      for (int i = 0; i < 32; i++) pushRead(i);
      applyStimulus(2'b10, 5'd0, 32'h0);
      waitAck(0, n);
      checkOutput("dump2_ack_latency", n, 32);

      // Request held high: accept at E0, ack at E1, re-accept at E2.
      pushWrite(3, 32'h0000_0033);
      pushWrite(4, 32'h0000_0044);
      dbg_req   = 1'b1;
      dbg_cmd   = 2'b01;
      dbg_addr  = 5'd3;
      dbg_wdata = 32'h0000_0033;
      @(posedge clk);
      #1;
      checkOutput("hold_busy_e0", dbg_busy, 1'b1);
      dbg_addr  = 5'd4;
      dbg_wdata = 32'h0000_0044;
      @(posedge clk);
      #1;
      checkOutput("hold_ack_e1", dbg_ack, 1'b1);
      checkOutput("hold_busy_e1", dbg_busy, 1'b0);
      @(posedge clk);
      #1 dbg_req = 1'b0;
      checkOutput("hold_busy_e2", dbg_busy, 1'b1);
      checkOutput("hold_wr_addr_e2", gpr_wr_addr, 5'd4);
      waitAck(0, n);
      checkOutput("hold_ack2_latency", n, 1);

      // Reset ten edges into a clear aborts it asynchronously without an ack.
      for (int i = 0; i < 10; i++) pushWrite(i, 32'h0);
      applyStimulus(2'b11, 5'd0, 32'h0);
      repeat (10) @(posedge clk);
      #1;
      ackBefore = ackCount;
      reset = 1'b0;
      #1;
      checkOutput("abort_we_n", gpr_we_n, 1'b1);
      checkOutput("abort_busy", dbg_busy, 1'b0);
      checkOutput("abort_ack", dbg_ack, 1'b0);
      checkOutput("abort_wr_addr", gpr_wr_addr, 5'd0);
      repeat (3) @(posedge clk);
      #1;
      checkOutput("abort_no_ack", ackCount, ackBefore);
      checkOutput("abort_writes_done", wrQ.size(), 0);

      // First request after release is accepted at the first edge.
      reset = 1'b1;
      pushWrite(20, 32'h0000_BEEF);
      applyStimulus(2'b01, 5'd20, 32'h0000_BEEF);
      checkOutput("post_reset_busy", dbg_busy, 1'b1);
      waitAck(0, n);
      checkOutput("post_reset_ack_latency", n, 1);
      pushRead(20);
      applyStimulus(2'b00, 5'd20, 32'h0);
      waitAck(0, n);
      checkOutput("post_reset_read_latency", n, 1);
      @(posedge clk);
      #1;
      checkOutput("rd_queue_empty", rdQ.size(), 0);
      checkOutput("wr_queue_empty", wrQ.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
